// File: rtl/udma_filter_tx_datafetch_2d.sv
// rtl/udma_filter_tx_datafetch_2d.sv - L2 read fetcher with linear/sliding/circular/2D address walks
// Grants reserve buffer space; SOF/EOF tags ride a side queue until their data returns.
module udma_filter_tx_datafetch_2d #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int TRANS_SIZE     = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      resetn_i,
    output logic                      tx_ch_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
    output logic [1:0]                tx_ch_datasize_o,
    input  logic                      tx_ch_gnt_i,
    input  logic                      tx_ch_valid_i,
    input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
    output logic                      tx_ch_ready_o,
    input  logic                      cmd_start_i,
    input  logic                      cmd_stop_i,
    output logic                      cmd_done_o,
    output logic                      busy_o,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
    output logic [DATA_WIDTH-1:0]     stream_data_o,
    output logic [1:0]                stream_datasize_o,
    output logic                      stream_valid_o,
    output logic                      stream_sof_o,
    output logic                      stream_eof_o,
    input  logic                      stream_ready_i
);
    localparam int AW = L2_AWIDTH_NOAL;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = FIFO_DEPTH[CW:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [AW-1:0]         start_q, cur_addr, base_addr, inc, stride, next_base;
    logic [1:0]            datasize_q, mode_q;
    logic [TRANS_SIZE-1:0] len0_q, len1_q, len2_q, elem_cnt, frame_cnt;
    logic [CW-1:0]         outstanding, count;
    logic [PW-1:0]         wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [1:0]            flag_mem [FIFO_DEPTH];
    logic [1:0]            tag_mem  [FIFO_DEPTH];
    logic                  aborting;
    logic                  grant, stop_hit, elem_last, last_elem, ret, push, pop, drained;

    assign stop_hit  = cmd_stop_i && (state != IDLE);
    assign grant     = tx_ch_req_o && tx_ch_gnt_i;
    assign elem_last = (elem_cnt == len0_q);
    assign last_elem = elem_last && ((mode_q == 2'd0) || (frame_cnt == len1_q));
    assign ret       = tx_ch_valid_i && (outstanding != '0);
    assign push      = ret && !aborting && !stop_hit;
    assign pop       = stream_valid_o && stream_ready_i;
    assign drained   = (outstanding == '0) && (count == '0);

    assign tx_ch_req_o       = (state == RUN) && !cmd_stop_i &&
                               (({1'b0, count} + {1'b0, outstanding}) < DEPTH_V);
    assign tx_ch_addr_o      = cur_addr;
    assign tx_ch_datasize_o  = datasize_q;
    assign tx_ch_ready_o     = 1'b1;
    assign busy_o            = (state != IDLE);
    assign cmd_done_o        = (state == DRAIN) && drained;
    assign stream_valid_o    = (count != '0) && !aborting && !stop_hit;
    assign stream_data_o     = data_mem[rd_ptr];
    assign stream_datasize_o = datasize_q;
    assign stream_sof_o      = stream_valid_o && flag_mem[rd_ptr][1];
    assign stream_eof_o      = stream_valid_o && flag_mem[rd_ptr][0];
    assign stride            = AW'(len2_q);

    always_comb begin
        inc = AW'(4);
        case (datasize_q)
            2'b00:   inc = AW'(1);
            2'b01:   inc = AW'(2);
            default: inc = AW'(4);
        endcase
    end

    always_comb begin
        next_base = start_q;
        case (mode_q)
            2'd1:    next_base = base_addr + inc;
            2'd3:    next_base = base_addr + stride;
            default: next_base = start_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_start_i) state_nxt = RUN;
            RUN:     if (cmd_stop_i || (grant && last_elem)) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            start_q     <= '0;
            cur_addr    <= '0;
            base_addr   <= '0;
            datasize_q  <= '0;
            mode_q      <= '0;
            len0_q      <= '0;
            len1_q      <= '0;
            len2_q      <= '0;
            elem_cnt    <= '0;
            frame_cnt   <= '0;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            aborting    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                flag_mem[i] <= '0;
                tag_mem[i]  <= '0;
            end
        end else begin
            if ((state == IDLE) && cmd_start_i) begin
                start_q    <= cfg_start_addr_i;
                cur_addr   <= cfg_start_addr_i;
                base_addr  <= cfg_start_addr_i;
                datasize_q <= cfg_datasize_i;
                mode_q     <= cfg_mode_i;
                len0_q     <= cfg_len0_i;
                len1_q     <= cfg_len1_i;
                len2_q     <= cfg_len2_i;
                elem_cnt   <= '0;
                frame_cnt  <= '0;
                aborting   <= 1'b0;
            end

            if (grant) begin
                tag_mem[tag_wr] <= {elem_cnt == '0, elem_last};
                tag_wr          <= tag_wr + PW'(1);
                if (elem_last) begin
                    elem_cnt  <= '0;
                    frame_cnt <= frame_cnt + TRANS_SIZE'(1);
                    base_addr <= next_base;
                    cur_addr  <= next_base;
                end else begin
                    elem_cnt <= elem_cnt + TRANS_SIZE'(1);
                    cur_addr <= cur_addr + inc;
                end
            end

            case ({grant, ret})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase

            if (push) begin
                data_mem[wr_ptr] <= tx_ch_data_i;
                flag_mem[wr_ptr] <= tag_mem[tag_rd];
                wr_ptr           <= wr_ptr + PW'(1);
                tag_rd           <= tag_rd + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            // Abort: drop everything buffered; in-flight returns are counted but not stored.
            if (stop_hit) begin
                aborting <= 1'b1;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                tag_rd   <= tag_wr;
            end
        end
    end
endmodule

// File: tb/tb_udma_filter_tx_datafetch_2d.sv
// tb/tb_udma_filter_tx_datafetch_2d.sv - scoreboard bench with an L2 responder model
module tb_udma_filter_tx_datafetch_2d;
    localparam int DW = 32, AW = 15, TS = 16, FD = 4;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          resetn_i;
    logic          tx_ch_req_o, tx_ch_gnt_i, tx_ch_valid_i, tx_ch_ready_o;
    logic [AW-1:0] tx_ch_addr_o;
    logic [1:0]    tx_ch_datasize_o;
    logic [DW-1:0] tx_ch_data_i;
    logic          cmd_start_i, cmd_stop_i, cmd_done_o, busy_o;
    logic [AW-1:0] cfg_start_addr_i;
    logic [1:0]    cfg_datasize_i, cfg_mode_i;
    logic [TS-1:0] cfg_len0_i, cfg_len1_i, cfg_len2_i;
    logic [DW-1:0] stream_data_o;
    logic [1:0]    stream_datasize_o;
    logic          stream_valid_o, stream_sof_o, stream_eof_o, stream_ready_i;

    always #5 clk = ~clk;

    udma_filter_tx_datafetch_2d #(.DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .resetn_i(resetn_i),
        .tx_ch_req_o(tx_ch_req_o), .tx_ch_addr_o(tx_ch_addr_o), .tx_ch_datasize_o(tx_ch_datasize_o),
        .tx_ch_gnt_i(tx_ch_gnt_i), .tx_ch_valid_i(tx_ch_valid_i), .tx_ch_data_i(tx_ch_data_i),
        .tx_ch_ready_o(tx_ch_ready_o), .cmd_start_i(cmd_start_i), .cmd_stop_i(cmd_stop_i),
        .cmd_done_o(cmd_done_o), .busy_o(busy_o), .cfg_start_addr_i(cfg_start_addr_i),
        .cfg_datasize_i(cfg_datasize_i), .cfg_mode_i(cfg_mode_i), .cfg_len0_i(cfg_len0_i),
        .cfg_len1_i(cfg_len1_i), .cfg_len2_i(cfg_len2_i), .stream_data_o(stream_data_o),
        .stream_datasize_o(stream_datasize_o), .stream_valid_o(stream_valid_o),
        .stream_sof_o(stream_sof_o), .stream_eof_o(stream_eof_o), .stream_ready_i(stream_ready_i)
    );

    int n_cmp = 0, n_bad = 0;
    int grants = 0, done_cnt = 0, g_seq = 0, exp_seq = 0;
    int grant_limit = BIG, resp_budget = BIG;
    bit gnt_en = 1, gnt_rand = 0, valid_rand = 0, ready_en = 1, ready_rand = 0;
    logic [1:0]    cur_dsz = 2'b00;
    logic [AW-1:0] exp_addr [$];
    logic [DW+1:0] exp_strm [$];
    logic [DW-1:0] pend [$];
    bit            prev_stall = 0;
    logic [DW+1:0] prev_s;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input bit sof, input bit eof);
        logic [15:0] s;
        s = exp_seq[15:0];
        exp_addr.push_back(a);
        exp_strm.push_back({s, 1'b0, a, sof, eof});
        exp_seq++;
    endtask

    // Reference walk: frames of (len0+1) elements, frame base chosen by mode.
    task automatic model(input int sa, input int dsz, input int md, input int l0, input int l1, input int l2);
        int incr, nf, base;
        incr = (dsz == 0) ? 1 : (dsz == 1) ? 2 : 4;
        nf   = (md == 0) ? 1 : l1 + 1;
        for (int f = 0; f < nf; f++) begin
            base = (md == 1) ? sa + f * incr : (md == 3) ? sa + f * l2 : sa;
            for (int e = 0; e <= l0; e++) push_exp(AW'(base + e * incr), e == 0, e == l0);
        end
    endtask

    // L2 responder and stream sink, driven just after the active edge.
    always @(posedge clk) begin
        #1;
        tx_ch_gnt_i = gnt_en && (grants < grant_limit) && (gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        if (pend.size() > 0 && resp_budget > 0 && (valid_rand ? ($urandom_range(0, 2) != 0) : 1'b1)) begin
            tx_ch_valid_i = 1'b1;
            tx_ch_data_i  = pend[0];
        end else begin
            tx_ch_valid_i = 1'b0;
            tx_ch_data_i  = $urandom;
        end
        stream_ready_i = ready_en && (ready_rand ? ($urandom_range(0, 1) != 0) : 1'b1);
    end

    // Monitor: handshakes that complete at the coming edge.
    always @(negedge clk) begin
        if (!resetn_i) begin
            prev_stall = 0;
        end else begin
            if (tx_ch_req_o && tx_ch_gnt_i) begin
                logic [15:0] s;
                s = g_seq[15:0];
                if (exp_addr.size() == 0) check("unexpected_grant", 1, 0);
                else check("grant_addr", tx_ch_addr_o, exp_addr.pop_front());
                pend.push_back({s, 1'b0, tx_ch_addr_o});
                g_seq++;
                grants++;
            end
            if (tx_ch_valid_i && pend.size() > 0) begin
                pend.delete(0);
                resp_budget--;
            end
            if (prev_stall && stream_valid_o)
                check("stall_hold", {stream_data_o, stream_sof_o, stream_eof_o}, prev_s);
            if (stream_valid_o && stream_ready_i) begin
                if (exp_strm.size() == 0) check("unexpected_stream", 1, 0);
                else check("stream_elem", {stream_data_o, stream_sof_o, stream_eof_o}, exp_strm.pop_front());
                check("stream_dsz", stream_datasize_o, cur_dsz);
            end
            prev_stall = stream_valid_o && !stream_ready_i;
            prev_s     = {stream_data_o, stream_sof_o, stream_eof_o};
            if (cmd_done_o) done_cnt++;
        end
    end

    task automatic start_cmd(input logic [AW-1:0] sa, input logic [1:0] dsz, input logic [1:0] md,
                             input logic [TS-1:0] l0, input logic [TS-1:0] l1, input logic [TS-1:0] l2);
        cur_dsz = dsz;
        @(posedge clk); #1;
        cfg_start_addr_i = sa; cfg_datasize_i = dsz; cfg_mode_i = md;
        cfg_len0_i = l0; cfg_len1_i = l1; cfg_len2_i = l2;
        cmd_start_i = 1'b1;
        @(posedge clk); #1;
        cmd_start_i = 1'b0;
        cfg_start_addr_i = AW'($urandom); cfg_datasize_i = 2'($urandom); cfg_mode_i = 2'($urandom);
        cfg_len0_i = TS'($urandom); cfg_len1_i = TS'($urandom); cfg_len2_i = TS'($urandom);
    endtask

    task automatic finish_cmd(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("addr_left", exp_addr.size(), 0);
        check("strm_left", exp_strm.size(), 0);
        @(negedge clk) check("idle_after", busy_o, 0);
        exp_addr.delete();
        exp_strm.delete();
        exp_seq = g_seq;
    endtask

    task automatic run_cmd(input int sa, input int dsz, input int md, input int l0, input int l1,
                           input int l2, input bit use_model);
        int d0;
        if (use_model) model(sa, dsz, md, l0, l1, l2);
        d0 = done_cnt;
        start_cmd(AW'(sa), 2'(dsz), 2'(md), TS'(l0), TS'(l1), TS'(l2));
        finish_cmd(d0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, g0;
        resetn_i = 1'b0; cmd_start_i = 0; cmd_stop_i = 0;
        tx_ch_gnt_i = 0; tx_ch_valid_i = 0; tx_ch_data_i = '0; stream_ready_i = 0;
        cfg_start_addr_i = '0; cfg_datasize_i = '0; cfg_mode_i = '0;
        cfg_len0_i = '0; cfg_len1_i = '0; cfg_len2_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) check("reset_outs",
            {tx_ch_req_o, cmd_done_o, busy_o, stream_valid_o, stream_sof_o, stream_eof_o}, 6'b0);
        @(posedge clk); #1 resetn_i = 1'b1;
        @(negedge clk) check("ready_tied", tx_ch_ready_o, 1);

        // Directed: linear, sliding and 2D with literal expectations
        push_exp(15'h100, 1, 0); push_exp(15'h104, 0, 0); push_exp(15'h108, 0, 0); push_exp(15'h10C, 0, 1);
        run_cmd('h100, 2, 0, 3, 0, 0, 0);
        push_exp(15'h0, 1, 0); push_exp(15'h1, 0, 1); push_exp(15'h1, 1, 0);
        push_exp(15'h2, 0, 1); push_exp(15'h2, 1, 0); push_exp(15'h3, 0, 1);
        run_cmd(0, 0, 1, 1, 2, 0, 0);
        push_exp(15'h40, 1, 0); push_exp(15'h42, 0, 1); push_exp(15'h60, 1, 0); push_exp(15'h62, 0, 1);
        run_cmd('h40, 1, 3, 1, 1, 'h20, 0);
        push_exp(15'h7FFF, 1, 1); push_exp(15'h7FFF, 1, 1);
        run_cmd('h7FFF, 0, 2, 0, 1, 0, 0);

        // Randomized commands with random grant/valid/ready timing
        gnt_rand = 1; valid_rand = 1; ready_rand = 1;
        for (int k = 0; k < 12; k++)
            run_cmd($urandom_range(0, (1 << AW) - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 65535), 1);

        // Back-pressure: buffer reservation caps grants at FIFO depth
        gnt_rand = 0; valid_rand = 0; ready_rand = 0; ready_en = 0;
        model('h200, 2, 0, 9, 0, 0);
        d0 = done_cnt; g0 = grants;
        start_cmd(15'h200, 2'd2, 2'd0, 16'd9, 16'd0, 16'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_grants", grants - g0, FD);
        check("bp_req_low", tx_ch_req_o, 0);
        ready_en = 1;
        finish_cmd(d0);

        // Abort with two requests in flight and one element buffered
        ready_en = 0; resp_budget = 1;
        model('h300, 2, 0, 15, 0, 0);
        d0 = done_cnt; g0 = grants; grant_limit = grants + 3;
        start_cmd(15'h300, 2'd2, 2'd0, 16'd15, 16'd0, 16'd0);
        for (int i = 0; i < 100 && !(grants == g0 + 3 && stream_valid_o); i++) @(posedge clk);
        @(negedge clk) check("pre_stop_valid", {stream_valid_o, 8'(grants - g0)}, {1'b1, 8'd3});
        @(posedge clk); #1 cmd_stop_i = 1'b1;
        @(negedge clk) check("stop_cut", {stream_valid_o, tx_ch_req_o}, 2'b00);
        @(posedge clk); #1 cmd_stop_i = 1'b0;
        exp_addr.delete(); exp_strm.delete();
        repeat (4) @(negedge clk) check("stop_no_req", {tx_ch_req_o, stream_valid_o}, 2'b00);
        check("stop_waiting", {busy_o, done_cnt == d0}, 2'b11);
        resp_budget = BIG; ready_en = 1;
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("stop_done", done_cnt - d0, 1);
        check("stop_pend", pend.size(), 0);
        @(negedge clk) check("stop_idle", busy_o, 0);
        grant_limit = BIG; exp_seq = g_seq;

        // Reset mid-transfer: abandoned, no done pulse
        gnt_rand = 1; valid_rand = 1;
        model('h10, 1, 2, 7, 3, 0);
        d0 = done_cnt;
        start_cmd(15'h10, 2'd1, 2'd2, 16'd7, 16'd3, 16'd0);
        repeat (6) @(posedge clk);
        #1 resetn_i = 1'b0;
        pend.delete();
        @(negedge clk) check("midreset_outs",
            {tx_ch_req_o, cmd_done_o, busy_o, stream_valid_o, stream_sof_o, stream_eof_o}, 6'b0);
        repeat (2) @(posedge clk);
        #1 resetn_i = 1'b1;
        exp_addr.delete(); exp_strm.delete(); exp_seq = g_seq;
        repeat (6) @(posedge clk);
        check("midreset_nodone", done_cnt - d0, 0);
        @(negedge clk) check("midreset_idle", {busy_o, tx_ch_req_o}, 2'b00);

        // Normal operation after reset
        run_cmd('h1234, 2, 3, 2, 2, 'h100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/udma_filter_tx_datafetch_2d.md
UDMA_FILTER_TX_DATAFETCH_2D -- requirements
Module: udma_filter_tx_datafetch_2d

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the L2 read data and of the stream data.
REQ-002 SHALL have parameter L2_AWIDTH_NOAL, default 15: width of the L2 address.
REQ-003 SHALL have parameter TRANS_SIZE, default 16: width of the length and stride fields.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: number of data buffer entries; must be a power of two, >=2.
REQ-005 SHALL have ports:
  - clk_i in 1: clock
  - resetn_i in 1: reset, asynchronous, active-low
  - tx_ch_req_o out 1: L2 read request
  - tx_ch_addr_o out L2_AWIDTH_NOAL: read address
  - tx_ch_datasize_o out 2: latched datasize
  - tx_ch_gnt_i in 1: request grant
  - tx_ch_valid_i in 1: read data valid
  - tx_ch_data_i in DATA_WIDTH: read data
  - tx_ch_ready_o out 1: read data ready
  - cmd_start_i in 1: start command
  - cmd_stop_i in 1: abort command
  - cmd_done_o out 1: single-cycle completion pulse
  - busy_o out 1: high in RUN or DRAIN
  - cfg_start_addr_i in L2_AWIDTH_NOAL: start address
  - cfg_datasize_i in 2: element size
  - cfg_mode_i in 2: access mode
  - cfg_len0_i in TRANS_SIZE: elements per frame minus 1
  - cfg_len1_i in TRANS_SIZE: frames minus 1
  - cfg_len2_i in TRANS_SIZE: 2D row stride in bytes
  - stream_data_o out DATA_WIDTH: stream data
  - stream_datasize_o out 2: stream element size
  - stream_valid_o out 1: stream data valid
  - stream_sof_o out 1: start of frame
  - stream_eof_o out 1: end of frame
  - stream_ready_i in 1: stream ready

Function
REQ-006 SHALL use states IDLE, RUN, DRAIN; IDLE->RUN on cmd_start_i; cmd_start_i ignored outside IDLE.
REQ-007 SHALL latch all cfg_* inputs on start; later cfg changes have no effect until the next start.
REQ-008 SHALL set the address increment from the latched datasize: 00 -> 1, 01 -> 2, 10 -> 4, 11 -> 4.
REQ-009 SHALL wrap all address arithmetic modulo 2^L2_AWIDTH_NOAL and counter arithmetic modulo 2^TRANS_SIZE.
REQ-010 SHALL drive tx_ch_req_o only in RUN and only when stored entries plus outstanding requests < FIFO_DEPTH; the first request is possible in the cycle after start.
REQ-011 SHALL hold tx_ch_addr_o stable while tx_ch_req_o is high and not granted; an element is consumed on req&gnt.
REQ-012 SHALL implement mode 0 (linear): cfg_len0+1 elements from the start address, one frame.
REQ-013 SHALL implement mode 1 (sliding): cfg_len1+1 frames of cfg_len0+1 elements; each frame starts one increment after the previous frame's start.
REQ-014 SHALL implement mode 2 (circular): cfg_len1+1 frames of cfg_len0+1 elements, each restarting at the start address.
REQ-015 SHALL implement mode 3 (2D): cfg_len1+1 rows of cfg_len0+1 elements; row n starts at start address + n*cfg_len2.
REQ-016 SHALL tag the first granted element of each frame SOF and the last EOF; a single-element frame carries both tags.
REQ-017 SHALL carry the tags in an in-order side queue pushed on grant and popped on tx_ch_valid_i; each tag appears on stream_sof_o/stream_eof_o with its element.
REQ-018 SHALL tie tx_ch_ready_o high because buffer space is reserved at grant; an element written on tx_ch_valid_i is presented on stream_valid_o no earlier than the next cycle.
REQ-019 SHALL hold stream data and tags stable while stream_valid_o=1 and stream_ready_i=0.
REQ-020 SHALL enter DRAIN on the grant of the last element; in DRAIN it SHALL pulse cmd_done_o for one cycle and return to IDLE once outstanding=0 and the buffer is empty.
REQ-021 SHALL handle cmd_stop_i in RUN or DRAIN as follows:
  - stop requests immediately and flush the buffer and tag queue
  - force stream_valid_o low
  - discard returning data and go to DRAIN
  - pulse cmd_done_o once outstanding reaches 0
REQ-022 SHALL process simultaneous push and pop of the buffer in the same cycle without changing the occupancy count.

Reset
REQ-023 SHALL on resetn_i low asynchronously set state IDLE, clear counters, pointers, buffer and queue, and drive tx_ch_req_o, cmd_done_o, busy_o, stream_valid_o, stream_sof_o and stream_eof_o to 0.
REQ-024 SHALL abandon any transfer on reset mid-operation, with no done pulse.

Verification
REQ-025 Mode 0, start 0x100, datasize 10, len0=3, gnt and ready always 1 -> addresses 0x100, 0x104, 0x108, 0x10C; SOF on the first element, EOF on the fourth; one cmd_done_o pulse.
REQ-026 Mode 1, start 0x0, datasize 00, len0=1, len1=2 -> addresses 0,1,1,2,2,3; EOF on every second element, SOF on the following element.
REQ-027 Mode 3, start 0x40, datasize 01, len0=1, len1=1, len2=0x20 -> addresses 0x40, 0x42, 0x60, 0x62.
REQ-028 FIFO_DEPTH=4, stream_ready_i=0 -> at most 4 grants, then tx_ch_req_o=0; stream_ready_i=1 resumes requests with no lost or duplicated data.
REQ-029 cmd_stop_i with 2 requests outstanding -> no new request, stream_valid_o=0, cmd_done_o pulses once the 2nd valid returns, state IDLE.
